// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data.
// Optional fetch starvation guard enabled by macro ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int LAT    = 2,
  parameter int STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          if_stall,
  output logic          mem_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_i_ack;
  logic          r_d_ack;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_done;
  logic          w_force_i;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_streak;

  assign w_force_i = i_req && (r_streak == 4'(STREAK));

  // Count data grants that overtook a waiting fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_grant_i) begin
      r_streak <= '0;
    end else if (w_grant_d) begin
      r_streak <= i_req ? r_streak + 4'd1 : 4'd0;
    end
  end
`else
  logic w_unused_streak;

  assign w_force_i       = 1'b0;
  assign w_unused_streak = |4'(STREAK);
`endif

  // Next state and grant decision
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (d_req && !w_force_i) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end else if (i_req) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (r_cnt == 4'd0) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Memory command, latency counter, acks and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      if (w_grant_i) begin
        r_mem_en   <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= i_addr;
        r_cnt      <= CNT_INIT;
      end else if (w_grant_d) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_cnt       <= CNT_INIT;
      end else if (w_done) begin
        r_mem_en <= 1'b0;
        r_mem_we <= 1'b0;
        if (r_state == BUSY_I) begin
          r_i_ack   <= 1'b1;
          r_i_rdata <= mem_rdata;
        end else begin
          r_d_ack <= 1'b1;
          if (!r_mem_we) r_d_rdata <= mem_rdata;
        end
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_stall  = i_req & ~r_i_ack;
  assign mem_stall = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Memory model answers reads by address and absorbs writes.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          if_stall;
  logic          mem_stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_pass = 0;
  int n_total = 0;

  logic [DW-1:0] i_q[$];
  logic [DW-1:0] d_q[$];
  logic [DW-1:0] mem_model[logic [AW-1:0]];
  logic [DW-1:0] exp_v;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .LAT(LAT), .STREAK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_model(
    input logic [AW-1:0] a
  );
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  always @(posedge clk)
    if (mem_en && mem_we) mem_model[mem_addr] = mem_wdata;

  always @(negedge clk)
    mem_rdata = mem_en ? rd_model(mem_addr) : '0;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (mem_en !== 1'b0) $display("FAIL rst_mem_en got=%b exp=0", mem_en);
    else n_pass++;
    n_total++;
    if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we);
    else n_pass++;
    n_total++;
    if (mem_addr !== '0) $display("FAIL rst_mem_addr got=%h exp=0", mem_addr);
    else n_pass++;
    n_total++;
    if (mem_wdata !== '0) $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata);
    else n_pass++;
    n_total++;
    if ({i_ack, d_ack} !== 2'b00) $display("FAIL rst_acks got=%b exp=00", {i_ack, d_ack});
    else n_pass++;
    n_total++;
    if (i_rdata !== '0) $display("FAIL rst_i_rdata got=%h exp=0", i_rdata);
    else n_pass++;
    n_total++;
    if (d_rdata !== '0) $display("FAIL rst_d_rdata got=%h exp=0", d_rdata);
    else n_pass++;
    i_req = 1'b1;
    d_req = 1'b1;
    #1;
    n_total++;
    if ({if_stall, mem_stall} !== 2'b11) $display("FAIL rst_stalls got=%b exp=11", {if_stall, mem_stall});
    else n_pass++;
    i_req = 1'b0;
    d_req = 1'b0;
    #1;
    n_total++;
    if ({if_stall, mem_stall} !== 2'b00) $display("FAIL rst_stalls_low got=%b exp=00", {if_stall, mem_stall});
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_fetch();
    int ack_at = 0;
    int en_cyc = 0;
    int st_cyc = 0;
    mem_model[32'h40] = 32'h8C02_0004;
    i_addr = 32'h40;
    i_req = 1'b1;
    i_q.push_back(32'h8C02_0004);
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      #0;
      if (if_stall) st_cyc++;
      @(posedge clk);
      #1;
      if (i_ack) begin
        ack_at = k;
        i_req = 1'b0;
        exp_v = i_q.pop_front();
        n_total++;
        if (i_rdata !== exp_v) $display("FAIL fetch_rdata got=%h exp=%h", i_rdata, exp_v);
        else n_pass++;
      end else if (mem_en && !mem_we && mem_addr == 32'h40) begin
        en_cyc++;
      end
    end
    n_total++;
    if (ack_at !== LAT + 1) $display("FAIL fetch_latency got=%0d exp=%0d", ack_at, LAT + 1);
    else n_pass++;
    n_total++;
    if (en_cyc !== LAT) $display("FAIL fetch_mem_en_cycles got=%0d exp=%0d", en_cyc, LAT);
    else n_pass++;
    n_total++;
    if (st_cyc !== LAT + 1) $display("FAIL fetch_stall_cycles got=%0d exp=%0d", st_cyc, LAT + 1);
    else n_pass++;
    n_total++;
    if (if_stall !== 1'b0) $display("FAIL fetch_stall_after got=%b exp=0", if_stall);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store();
    int ack_at = 0;
    int we_cyc = 0;
    d_we = 1'b1;
    d_addr = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    d_req = 1'b1;
    d_q.push_back(32'h0);
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      @(posedge clk);
      #1;
      if (d_ack) begin
        ack_at = k;
        d_req = 1'b0;
        d_we = 1'b0;
        exp_v = d_q.pop_front();
        n_total++;
        if (d_rdata !== exp_v) $display("FAIL store_d_rdata got=%h exp=%h", d_rdata, exp_v);
        else n_pass++;
      end else if (mem_en && mem_we && mem_addr == 32'h100 && mem_wdata == 32'hDEAD_BEEF) begin
        we_cyc++;
      end
    end
    n_total++;
    if (ack_at !== LAT + 1) $display("FAIL store_latency got=%0d exp=%0d", ack_at, LAT + 1);
    else n_pass++;
    n_total++;
    if (we_cyc !== LAT) $display("FAIL store_we_cycles got=%0d exp=%0d", we_cyc, LAT);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_back();
    int ack_at = 0;
    d_we = 1'b0;
    d_addr = 32'h100;
    d_req = 1'b1;
    d_q.push_back(32'hDEAD_BEEF);
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      @(posedge clk);
      #1;
      if (d_ack) begin
        ack_at = k;
        d_req = 1'b0;
        exp_v = d_q.pop_front();
        n_total++;
        if (d_rdata !== exp_v) $display("FAIL load_back_rdata got=%h exp=%h", d_rdata, exp_v);
        else n_pass++;
      end
    end
    n_total++;
    if (ack_at !== LAT + 1) $display("FAIL load_back_latency got=%0d exp=%0d", ack_at, LAT + 1);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_collision();
    int d_at = 0;
    int i_at = 0;
    logic [AW-1:0] first_addr = '1;
    mem_model[32'h200] = 32'h1234_5678;
    d_we = 1'b0;
    d_addr = 32'h200;
    i_addr = 32'h44;
    d_q.push_back(32'h1234_5678);
    i_q.push_back(rd_model(32'h44));
    d_req = 1'b1;
    i_req = 1'b1;
    for (int k = 1; k <= 30 && (i_req || d_req); k++) begin
      @(posedge clk);
      #1;
      if (k == 1) first_addr = mem_addr;
      if (d_ack) begin
        d_at = k;
        d_req = 1'b0;
        exp_v = d_q.pop_front();
        n_total++;
        if (d_rdata !== exp_v) $display("FAIL coll_d_rdata got=%h exp=%h", d_rdata, exp_v);
        else n_pass++;
      end
      if (i_ack) begin
        i_at = k;
        i_req = 1'b0;
        exp_v = i_q.pop_front();
        n_total++;
        if (i_rdata !== exp_v) $display("FAIL coll_i_rdata got=%h exp=%h", i_rdata, exp_v);
        else n_pass++;
      end
    end
    n_total++;
    if (first_addr !== 32'h200) $display("FAIL coll_first_grant got=%h exp=%h", first_addr, 32'h200);
    else n_pass++;
    n_total++;
    if (d_at !== 3) $display("FAIL coll_d_ack_cycle got=%0d exp=3", d_at);
    else n_pass++;
    n_total++;
    if (i_at !== 6) $display("FAIL coll_i_ack_cycle got=%0d exp=6", i_at);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int t[3];
    int n = 0;
    i_addr = 32'h0;
    i_q.push_back(rd_model(32'h0));
    i_req = 1'b1;
    for (int k = 1; k <= 40 && i_req; k++) begin
      @(posedge clk);
      #1;
      if (i_ack) begin
        t[n] = k;
        n++;
        exp_v = i_q.pop_front();
        n_total++;
        if (i_rdata !== exp_v) $display("FAIL b2b_rdata%0d got=%h exp=%h", n, i_rdata, exp_v);
        else n_pass++;
        if (n < 3) begin
          i_addr = 32'(4 * n);
          i_q.push_back(rd_model(i_addr));
        end else begin
          i_req = 1'b0;
        end
      end
    end
    n_total++;
    if (n !== 3) $display("FAIL b2b_count got=%0d exp=3", n);
    else n_pass++;
    n_total++;
    if (t[1] - t[0] !== LAT + 1) $display("FAIL b2b_gap1 got=%0d exp=%0d", t[1] - t[0], LAT + 1);
    else n_pass++;
    n_total++;
    if (t[2] - t[1] !== LAT + 1) $display("FAIL b2b_gap2 got=%0d exp=%0d", t[2] - t[1], LAT + 1);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_starve();
    int acks = 0;
    int nd = 0;
    int pos_i = 0;
    int exp_pos;
    logic [AW-1:0] a = 32'h1000;
`ifdef ARB_STARVE_GUARD_EN
    exp_pos = 5;
`else
    exp_pos = 7;
`endif
    d_we = 1'b0;
    d_addr = a;
    d_q.push_back(rd_model(a));
    i_addr = 32'h80;
    i_q.push_back(rd_model(32'h80));
    d_req = 1'b1;
    i_req = 1'b1;
    for (int k = 1; k <= 80 && (i_req || d_req); k++) begin
      @(posedge clk);
      #1;
      if (d_ack) begin
        acks++;
        nd++;
        exp_v = d_q.pop_front();
        n_total++;
        if (d_rdata !== exp_v) $display("FAIL starve_d_rdata%0d got=%h exp=%h", nd, d_rdata, exp_v);
        else n_pass++;
        if (nd >= 6) begin
          d_req = 1'b0;
        end else begin
          a = a + 32'd4;
          d_addr = a;
          d_q.push_back(rd_model(a));
        end
      end
      if (i_ack) begin
        acks++;
        pos_i = acks;
        i_req = 1'b0;
        exp_v = i_q.pop_front();
        n_total++;
        if (i_rdata !== exp_v) $display("FAIL starve_i_rdata got=%h exp=%h", i_rdata, exp_v);
        else n_pass++;
      end
    end
    n_total++;
    if (pos_i !== exp_pos) $display("FAIL starve_fetch_pos got=%0d exp=%0d", pos_i, exp_pos);
    else n_pass++;
    n_total++;
    if (nd !== 6) $display("FAIL starve_data_acks got=%0d exp=6", nd);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int ack_at = 0;
    int bad_acks = 0;
    mem_model[32'h300] = 32'h0BAD_F00D;
    d_we = 1'b0;
    d_addr = 32'h300;
    d_req = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (mem_en !== 1'b1) $display("FAIL rmid_busy got=%b exp=1", mem_en);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (mem_en !== 1'b0) $display("FAIL rmid_mem_en_async got=%b exp=0", mem_en);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (d_ack) bad_acks++;
    end
    rst_n = 1'b1;
    d_q.push_back(32'h0BAD_F00D);
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      @(posedge clk);
      #1;
      if (d_ack) begin
        ack_at = k;
        d_req = 1'b0;
        exp_v = d_q.pop_front();
        n_total++;
        if (d_rdata !== exp_v) $display("FAIL rmid_rdata got=%h exp=%h", d_rdata, exp_v);
        else n_pass++;
      end
    end
    n_total++;
    if (bad_acks !== 0) $display("FAIL rmid_no_ack got=%0d exp=0", bad_acks);
    else n_pass++;
    n_total++;
    if (ack_at !== LAT + 1) $display("FAIL rmid_reissue_latency got=%0d exp=%0d", ack_at, LAT + 1);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_load_back();
    test_collision();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
